// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider.
// Produces a divided clock, a one-cycle TICK at each divided-clock rise,
// and glitch-free reload of the divide ratio at period boundaries.
// Default output is 50% duty for odd and even N. A half-cycle falling-edge
// flop is used to trim the high time for odd N.
// Optional feature macro: CLK_DIV_DUTY_EN. When it is defined, a DUTY port
// is added. DUTY sets the high time in CLK cycles, and the odd-N correction
// is dropped.

module clk_div_prog #(
    parameter int unsigned W         = 32,
    parameter int unsigned DEFAULT_N = 32'd67108864
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] DIV_N,
`ifdef CLK_DIV_DUTY_EN
    input  logic [W-1:0] DUTY,
`endif
    input  logic         LOAD,
    output logic         LOAD_ACK,
    output logic         CLK_OUT,
    output logic         TICK,
    output logic         BUSY
);

    localparam logic [W-1:0] N_RST = W'(DEFAULT_N);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] n_act_q, n_act_d;
    logic [W-1:0] n_pend_q, n_pend_d;
    logic         busy_q, busy_d;
    logic         ack_q, ack_d;
    logic         tick_q, tick_d;
    logic         qp_q, qp_d;
    logic         last_c;
    logic         apply_c;

`ifdef CLK_DIV_DUTY_EN
    localparam logic [W-1:0] DUTY_RST = W'(DEFAULT_N >> 1);

    logic [W-1:0] duty_pend_q, duty_pend_d;
    logic [W-1:0] duty_act_q, duty_act_d;
`else
    logic         odd_q, odd_d;
    logic         qn_q;
    logic [W-1:0] half_c;
`endif

    // Ratios below 2 cannot form a high and a low phase, so they map to 2
    function automatic logic [W-1:0] clamp_n(input logic [W-1:0] n);
        return (n < W'(2)) ? W'(2) : n;
    endfunction

    // Last count of the current period: the wrap / reload boundary
    assign last_c = (cnt_q == (n_act_q - W'(1)));

    // Next-state: run/idle control, counter, pending-load bookkeeping and output levels
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_act_d  = n_act_q;
        n_pend_d = n_pend_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        apply_c  = 1'b0;
`ifdef CLK_DIV_DUTY_EN
        duty_pend_d = duty_pend_q;
        duty_act_d  = duty_act_q;
`else
        odd_d       = odd_q;
        half_c      = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                apply_c = busy_q;
                if (EN) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_c) begin
                    cnt_d   = '0;
                    apply_c = busy_q;
                    // A stop request only takes effect once the period completes
                    if (!EN) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Adopt the pending ratio, so the next period already uses it
        if (apply_c) begin
            n_act_d = n_pend_q;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
`ifdef CLK_DIV_DUTY_EN
            duty_act_d = duty_pend_q;
`endif
        end

        // A new request overwrites any pending value. If it coincides with an
        // apply, the new request stays pending.
        if (LOAD) begin
            n_pend_d = clamp_n(DIV_N);
            busy_d   = 1'b1;
`ifdef CLK_DIV_DUTY_EN
            duty_pend_d = DUTY;
`endif
        end

        tick_d = (state_d == ST_RUN) && (cnt_d == '0);

`ifdef CLK_DIV_DUTY_EN
        qp_d = (state_d == ST_RUN) && (cnt_d < duty_act_d);
`else
        // High for ceil(N/2) counts; the odd case is trimmed later by qn_q
        odd_d  = n_act_d[0];
        half_c = (n_act_d >> 1) + W'(n_act_d[0]);
        qp_d   = (state_d == ST_RUN) && (cnt_d < half_c);
`endif
    end

    // Rising-edge state, counter and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            n_act_q  <= N_RST;
            n_pend_q <= N_RST;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            tick_q   <= 1'b0;
            qp_q     <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
            duty_pend_q <= DUTY_RST;
            duty_act_q  <= DUTY_RST;
`else
            odd_q       <= N_RST[0];
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_act_q  <= n_act_d;
            n_pend_q <= n_pend_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            tick_q   <= tick_d;
            qp_q     <= qp_d;
`ifdef CLK_DIV_DUTY_EN
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
`else
            odd_q       <= odd_d;
`endif
        end
    end

`ifdef CLK_DIV_DUTY_EN
    assign CLK_OUT = qp_q;
`else
    // Half-cycle delayed copy of qp_q, used to shave half a CLK off odd-N high time
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            qn_q <= 1'b0;
        end else begin
            qn_q <= qp_q;
        end
    end

    assign CLK_OUT = odd_q ? (qp_q & qn_q) : qp_q;
`endif

    assign LOAD_ACK = ack_q;
    assign TICK     = tick_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized scoreboard bench for clk_div_prog (default build, 50% duty).
// The reference model tracks the period position and the pending load.
// It predicts CLK_OUT at half-cycle resolution: a period of N spans 2N
// half-slots. The output is high for exactly N of them. The high run starts
// at slot 0 for even N and at slot 1 for odd N.

module tb_clk_div_prog;

    localparam int unsigned W     = 16;
    localparam int          DEF_N = 4;
    localparam int          NCYC  = 4000;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic [W-1:0] DIV_N;
    logic         LOAD;
    logic         LOAD_ACK;
    logic         CLK_OUT;
    logic         TICK;
    logic         BUSY;

    clk_div_prog #(
        .W         (W),
        .DEFAULT_N (DEF_N)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .DIV_N    (DIV_N),
        .LOAD     (LOAD),
        .LOAD_ACK (LOAD_ACK),
        .CLK_OUT  (CLK_OUT),
        .TICK     (TICK),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit tick;
        bit ack;
        bit busy;
        bit hi1;
        bit hi2;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   rst_gen = 0;
    bit   mon_en  = 1'b0;
    bit   rst_arm = 1'b0;

    // Reference model state
    bit m_run;
    int m_pos;
    int m_n;
    bit m_pend_v;
    int m_pend;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit slot_high(input int n, input int pos, input int half);
        int s;
        int off;
        s   = 2 * pos + half;
        off = n % 2;
        return (s >= off) && (s < off + n);
    endfunction

    task automatic model_reset();
        m_run    = 1'b0;
        m_pos    = 0;
        m_n      = DEF_N;
        m_pend_v = 1'b0;
        m_pend   = DEF_N;
    endtask

    // Advance the model by one rising edge, given the inputs seen at that edge
    task automatic model_step(input bit en, input bit load, input int dn, output exp_t e);
        bit apply;
        apply = m_pend_v && (!m_run || (m_pos == m_n - 1));
        if (m_run) begin
            if (m_pos == m_n - 1) begin
                m_pos = 0;
                m_run = en;
            end else begin
                m_pos++;
            end
        end else if (en) begin
            m_run = 1'b1;
            m_pos = 0;
        end
        e.ack = apply;
        if (apply) begin
            m_n      = m_pend;
            m_pend_v = 1'b0;
        end
        if (load) begin
            m_pend   = (dn < 2) ? 2 : dn;
            m_pend_v = 1'b1;
        end
        e.tick = m_run && (m_pos == 0);
        e.busy = m_pend_v;
        e.hi1  = m_run && slot_high(m_n, m_pos, 0);
        e.hi2  = m_run && slot_high(m_n, m_pos, 1);
    endtask

    // Monitor: pop one expectation per cycle; check both halves of CLK_OUT
    initial begin : monitor
        exp_t cur;
        bit   have;
        int   gen;
        have = 1'b0;
        gen  = 0;
        forever begin
            @(posedge CLK);
            #1;
            have = 1'b0;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1'b1;
                    gen  = rst_gen;
                    chk("tick", TICK, cur.tick);
                    chk("load_ack", LOAD_ACK, cur.ack);
                    chk("busy", BUSY, cur.busy);
                    chk("clk_out_first_half", CLK_OUT, cur.hi1);
                end
            end
            @(negedge CLK);
            #1;
            if (have && mon_en && (gen == rst_gen)) begin
                chk("clk_out_second_half", CLK_OUT, cur.hi2);
            end
        end
    end

    // Stimulus: random EN/LOAD/DIV_N, occasional async reset with a load pending
    initial begin : stimulus
        RST   = 1'b1;
        EN    = 1'b0;
        LOAD  = 1'b0;
        DIV_N = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_clk_out", CLK_OUT, 1'b0);
        chk("reset_tick", TICK, 1'b0);
        chk("reset_load_ack", LOAD_ACK, 1'b0);
        chk("reset_busy", BUSY, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < NCYC; i++) begin
            bit   en;
            bit   ld;
            int   dn;
            exp_t e;
            if ((i % 500) == 250) begin
                rst_arm = 1'b1;
            end
            dn = int'($urandom_range(0, 12));
            if (i < 16) begin
                en = 1'b1;
                ld = 1'b0;
            end else begin
                en = ($urandom_range(0, 19) != 0);
                ld = ($urandom_range(0, 11) == 0);
                // Bias towards a load on the very edge that applies the pending one
                if (m_pend_v && m_run && (m_pos == m_n - 1) && ($urandom_range(0, 1) == 1)) begin
                    ld = 1'b1;
                end
                if (rst_arm && ($urandom_range(0, 3) == 0)) begin
                    ld = 1'b1;
                end
            end
            EN    = en;
            LOAD  = ld;
            DIV_N = W'(dn);
            model_step(en, ld, dn, e);
            exp_q.push_back(e);
            mon_en = 1'b1;

            @(posedge CLK);
            #3;
            if (rst_arm && e.hi1 && m_pend_v) begin
                RST = 1'b1;
                rst_gen++;
                #1;
                chk("async_rst_clk_out", CLK_OUT, 1'b0);
                chk("async_rst_busy", BUSY, 1'b0);
                chk("async_rst_tick", TICK, 1'b0);
                chk("async_rst_load_ack", LOAD_ACK, 1'b0);
                @(negedge CLK);
                RST = 1'b0;
                exp_q.delete();
                model_reset();
                rst_arm = 1'b0;
            end else begin
                @(negedge CLK);
            end
        end

        #2;
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider. It generalises the fixed-N divider in width and N, and adds run-time reload, enable/stop control and a tick strobe. It produces a 50%-duty divided clock for both odd and even N, changes N glitch-free only at period boundaries, and provides a single-cycle tick for synchronous logic. It sits between the board clock and slow consumers such as LED blinkers, scan multiplexers and debouncers.

Parameters:
W, 32, width of DIV_N and the internal counter
DEFAULT_N, 67108864 (2**26), divide ratio after reset; must satisfy 2 <= DEFAULT_N < 2**W

Ports:
CLK  input  1  system clock; only clock in the block (rising edge, plus one falling-edge flop)
RST  input  1  asynchronous, active-high reset
EN  input  1  run enable, level
DIV_N  input  W  requested divide ratio, sampled when LOAD=1
LOAD  input  1  one-cycle request to adopt DIV_N
LOAD_ACK  output  1  one-cycle pulse when the pending N becomes active
CLK_OUT  output  1  divided clock
TICK  output  1  one-CLK-cycle pulse at each CLK_OUT rising edge
BUSY  output  1  1 while a loaded N is pending and not yet applied

Behaviour:
- Reset (async): n_act=DEFAULT_N, cnt=0, state=IDLE. CLK_OUT, TICK, LOAD_ACK and BUSY are all 0. The negedge flop also clears.
- Clamp: a loaded DIV_N of 0 or 1 is stored as 2.
- States:
  - IDLE: cnt held at 0, CLK_OUT=0. Goes to RUN on the first posedge with EN=1; that cycle is cnt=0.
  - RUN: cnt counts 0..n_act-1 and wraps to 0. If EN=0 at the cnt==n_act-1 edge, goes to IDLE (the current period always completes; there are no runt pulses).
- Posedge flop q_p:
  - Even N: q_p=1 for cnt in [0, N/2-1].
  - Odd N: q_p=1 for cnt in [0, (N-1)/2].
- Falling-edge flop q_n samples q_p on negedge CLK.
- Output:
  - CLK_OUT = q_p when n_act is even.
  - CLK_OUT = q_p & q_n when n_act is odd, giving a high time of N/2 CLK periods (exact 50%).
  - The odd/even select is registered with n_act.
- TICK=1 in the cycle where cnt==0 and state=RUN. Its latency is 0 relative to the CLK_OUT rise.
- Load handling:
  - LOAD=1 writes the clamped DIV_N into n_pend and sets BUSY=1 on the next edge.
  - In RUN, n_pend is applied at the cnt==n_act-1 edge, so the next period uses the new N.
  - In IDLE, n_pend is applied on the next edge.
  - On apply: LOAD_ACK pulses for one cycle and BUSY clears.
- A LOAD while BUSY overwrites n_pend; only one LOAD_ACK is issued for the final value.
- LOAD in the same cycle as the apply edge: the old n_pend is applied and acked, the new value becomes pending, and BUSY stays 1.
- EN toggling never alters n_act or n_pend.
- RST asserted mid-period: CLK_OUT goes to 0 immediately (async), and any pending load is discarded.

Optional Feature:
CLK_DIV_DUTY_EN
- With the macro defined: adds input DUTY (W bits), sampled with LOAD into a pending duty register and applied together with N.
  - q_p=1 for cnt < DUTY, so the high time is DUTY CLK cycles.
  - DUTY=0 gives constant 0; DUTY>=N gives constant 1 and TICK is still generated.
  - The odd-N half-cycle correction is disabled and CLK_OUT = q_p.
- Without the macro: no DUTY port; fixed 50% duty as described above.

Test Plan:
1. Reset with DEFAULT_N overridden to 4, EN=1 -> CLK_OUT high for 2 CLK and low for 2 CLK, repeating; TICK pulses every 4 cycles, aligned to each rise.
2. LOAD DIV_N=5 mid-period with EN=1 -> BUSY=1 until the wrap; LOAD_ACK on the wrap edge; then period = 5 CLK with high time = 2.5 CLK (checked at negedge resolution).
3. LOAD DIV_N=1 -> n_act becomes 2; CLK_OUT toggles every CLK cycle.
4. Deassert EN at cnt=1 with N=6 -> the period completes through cnt=5, then CLK_OUT stays 0 and TICK stays 0. Reassert EN -> TICK and CLK_OUT rise on the next edge.
5. LOAD 8 then LOAD 10 before the wrap, plus a third LOAD coincident with the apply edge -> exactly one LOAD_ACK per applied value, the last value is honoured, and BUSY stays 1 correctly through the coincidence.
6. Assert RST while CLK_OUT=1 with a pending load -> CLK_OUT, BUSY and TICK go to 0 asynchronously; after release, the DEFAULT_N period resumes.
